// File: rtl/iir_capture_sequencer.sv
// rtl/iir_capture_sequencer.sv - IIR filter run controller: clear, settle, capture into FIFO.
// Define IIR_SEQ_AUTORESTART_EN to re-run automatically from DONE with the same latched counts.
module iir_capture_sequencer #(
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] settle_samples,
  input  logic [CNT_W-1:0] capture_samples,
  input  logic             in_valid,
  input  logic             fifo_full,
  output logic             filt_reset_n,
  output logic             filt_enable,
  output logic             filt_data_valid,
  output logic             fifo_wr,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int               CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [CLR_W-1:0] clear_cnt;
  logic [CNT_W-1:0] settle_target;
  logic [CNT_W-1:0] capture_target;
  logic [CNT_W-1:0] count_inc;
  logic             run_start;
  logic             capture_accept;

  assign count_inc      = sample_count + CNT_ONE;
  assign run_start      = (state == S_IDLE) && (next_state == S_CLEAR);
  assign capture_accept = (state == S_CAPTURE) && filt_data_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      filt_reset_n   <= 1'b0;
      fifo_wr        <= 1'b0;
      overflow       <= 1'b0;
      sample_count   <= '0;
      clear_cnt      <= '0;
      settle_target  <= '0;
      capture_target <= '0;
    end else begin
      state        <= next_state;
      filt_reset_n <= (next_state != S_CLEAR);
      // The filter output register holds this sample's result one cycle later.
      fifo_wr      <= capture_accept && !fifo_full;
      clear_cnt    <= (state == S_CLEAR && next_state == S_CLEAR) ? clear_cnt + CLR_ONE : '0;

      if (run_start) begin
        settle_target  <= settle_samples;
        capture_target <= capture_samples;
        overflow       <= 1'b0;
      end else if (capture_accept && fifo_full && !abort) begin
        overflow <= 1'b1;
      end

      if (state != S_CLEAR && next_state == S_CLEAR) begin
        sample_count <= '0;
      end else if (filt_data_valid) begin
        if (state == S_SETTLE) begin
          sample_count <= (count_inc == settle_target) ? '0 : count_inc;
        end else if (sample_count != capture_target) begin
          sample_count <= count_inc;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        if (clear_cnt == CLR_LAST) begin
          next_state = (settle_target == '0) ? S_CAPTURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (filt_data_valid && count_inc == settle_target) next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (capture_target == '0) begin
          next_state = S_DONE;
        end else if (filt_data_valid && (fifo_full || count_inc == capture_target)) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
`ifdef IIR_SEQ_AUTORESTART_EN
        next_state = overflow ? S_IDLE : S_CLEAR;
`else
        next_state = S_IDLE;
`endif
      end
      default: next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  always_comb begin
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    filt_enable     = (state == S_SETTLE) || ((state == S_CAPTURE) && (capture_target != '0));
    filt_data_valid = in_valid && filt_enable;
  end

endmodule

// File: tb/tb_iir_capture_sequencer.sv
// tb/tb_iir_capture_sequencer.sv - randomized scoreboard bench for iir_capture_sequencer.
// Honours IIR_SEQ_AUTORESTART_EN when the design is built with it.
module tb_iir_capture_sequencer;

  localparam int CLEAR_CYCLES = 2;
  localparam int CNT_W        = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] settle_samples;
  logic [CNT_W-1:0] capture_samples;
  logic             in_valid;
  logic             fifo_full;
  logic             filt_reset_n;
  logic             filt_enable;
  logic             filt_data_valid;
  logic             fifo_wr;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] sample_count;

  always #5 clock = ~clock;

  iir_capture_sequencer #(
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .settle_samples (settle_samples),
    .capture_samples(capture_samples),
    .in_valid       (in_valid),
    .fifo_full      (fifo_full),
    .filt_reset_n   (filt_reset_n),
    .filt_enable    (filt_enable),
    .filt_data_valid(filt_data_valid),
    .fifo_wr        (fifo_wr),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .sample_count   (sample_count)
  );

  // Expected observable state just after one clock edge.
  typedef struct {
    logic             rn;
    logic             en;
    logic             fdv;
    logic             wr;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [CNT_W-1:0] sc;
    logic             chk;
    int               scen;
    int               idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  int   scen = 0;
  int   sc = 0;
  logic sc_known = 1'b1;
  logic exp_ovf = 1'b0;
  logic tog = 1'b0;

  function automatic exp_t mk(input logic rn, input logic en, input logic wr,
                              input logic bsy, input logic dn);
    exp_t e;
    e.rn   = rn;
    e.en   = en;
    e.fdv  = 1'b0;
    e.wr   = wr;
    e.busy = bsy;
    e.done = dn;
    e.ovf  = exp_ovf;
    e.sc   = CNT_W'(sc);
    e.chk  = sc_known;
    e.scen = scen;
    e.idx  = 0;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic pick_v(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin
      tog = ~tog;
      return tog;
    end
    return ($urandom_range(0, 9) < 7);
  endfunction

  // Drive inputs for the next edge and queue what the outputs must look like after it.
  task automatic step(input logic st, input logic ab, input logic v, input logic f,
                      input logic rs, input exp_t e);
    start     = st;
    abort     = ab;
    in_valid  = v;
    fifo_full = f;
    reset     = rs;
    e.fdv     = v & e.en;
    e.idx     = step_no;
    step_no++;
    sb.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rbit(), rbit(), 1'b0, mk(1, 0, 0, 0, 0));
  endtask

  // One run from start: full_at is the 0-based capture sample that meets a full FIFO,
  // abort_at / reset_at are step numbers inside the sampling phase (-1 = never).
  task automatic run(input int settle, input int capture, input int mode,
                     input int full_at, input int abort_at, input int reset_at);
    int   s_left, c_left, k, n, restarts, ab_at;
    logic v, f, st, ab, rs, wr, fin, done_now, first;
    ab_at    = abort_at;
    n        = 0;
    restarts = 0;
    first    = 1'b1;
    forever begin
      settle_samples  = CNT_W'(settle);
      capture_samples = CNT_W'(capture);
      sc       = 0;
      sc_known = 1'b1;
      exp_ovf  = 1'b0;
      step(first ? 1'b1 : rbit(), 1'b0, rbit(), rbit(), 1'b0, mk(0, 0, 0, 1, 0));
      for (int i = 1; i < CLEAR_CYCLES; i++) begin
        settle_samples  = CNT_W'($urandom);
        capture_samples = CNT_W'($urandom);
        step(1'b0, 1'b0, rbit(), rbit(), 1'b0, mk(0, 0, 0, 1, 0));
      end
      step(rbit(), 1'b0, rbit(), rbit(), 1'b0, mk(1, (settle > 0) || (capture > 0), 0, 1, 0));
      s_left = settle;
      c_left = capture;
      k      = 0;
      fin    = 1'b0;
      while (!fin) begin
        settle_samples  = CNT_W'($urandom);
        capture_samples = CNT_W'($urandom);
        v        = pick_v(mode);
        st       = ($urandom_range(0, 9) == 0);
        f        = rbit();
        ab       = (n == ab_at);
        rs       = (n == reset_at);
        wr       = 1'b0;
        done_now = 1'b0;
        if (s_left > 0) begin
          if (v) begin
            sc++;
            s_left--;
            if (s_left == 0) sc = 0;
          end
        end else if (capture == 0) begin
          done_now = 1'b1;
        end else if (v) begin
          f = (k == full_at);
          k++;
          sc++;
          if (f) begin
            if (!ab) exp_ovf = 1'b1;
            done_now = 1'b1;
          end else begin
            wr = 1'b1;
            c_left--;
            if (c_left == 0) done_now = 1'b1;
          end
        end
        n++;
        if (rs) begin
          exp_ovf  = 1'b0;
          sc       = 0;
          sc_known = 1'b1;
          step(1'b0, ab, v, f, 1'b1, mk(0, 0, 0, 0, 0));
          step(1'b0, 1'b0, rbit(), rbit(), 1'b0, mk(1, 0, 0, 0, 0));
          return;
        end
        if (ab) begin
          if (v) sc_known = 1'b0;
          step(st, 1'b1, v, f, 1'b0, mk(1, 0, wr, 0, 0));
          step(1'b0, 1'b0, rbit(), rbit(), 1'b0, mk(1, 0, 0, 0, 0));
          return;
        end
        if (done_now) begin
          step(st, 1'b0, v, f, 1'b0, mk(1, 0, wr, 1, 1));
          fin = 1'b1;
        end else begin
          step(st, 1'b0, v, f, 1'b0, mk(1, (s_left > 0) || (capture > 0), wr, 1, 0));
        end
        if (n > 600) begin
          checks++;
          errors++;
          $display("FAIL run%0d step_budget: got no completion after %0d steps, expected done", scen, n);
          return;
        end
      end
`ifdef IIR_SEQ_AUTORESTART_EN
      if (!exp_ovf) begin
        restarts++;
        first = 1'b0;
        if (restarts >= 2 && ab_at < 0) ab_at = n;
        continue;
      end
`endif
      step(rbit(), 1'b0, rbit(), rbit(), 1'b0, mk(1, 0, 0, 0, 0));
      return;
    end
  endtask

  exp_t mon_e;
  logic [6:0] mon_act;
  logic [6:0] mon_exp;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = {filt_reset_n, filt_enable, filt_data_valid, fifo_wr, busy, done, overflow};
      mon_exp = {mon_e.rn, mon_e.en, mon_e.fdv, mon_e.wr, mon_e.busy, mon_e.done, mon_e.ovf};
      checks++;
      if (mon_act !== mon_exp || (mon_e.chk && sample_count !== mon_e.sc)) begin
        errors++;
        $display("FAIL run%0d step%0d: got rn,en,dv,wr,busy,done,ovf=%b sc=%0d, expected %b sc=%0d%s",
                 mon_e.scen, mon_e.idx, mon_act, sample_count, mon_exp, mon_e.sc,
                 mon_e.chk ? "" : " (sc free)");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, c, fa, aa;
    reset           = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    in_valid        = 1'b0;
    fifo_full       = 1'b0;
    settle_samples  = '0;
    capture_samples = '0;
    repeat (3) @(negedge clock);
    #1;

    scen = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0));
    idle_steps(2);

    scen = 1; run(4, 8, 0, -1, -1, -1); idle_steps(2);
    scen = 2; run(0, 5, 1, -1, -1, -1); idle_steps(2);
    scen = 3; run(2, 6, 0, 2, -1, -1);  idle_steps(3);

    // Start with abort from IDLE is ignored and leaves overflow sticky.
    scen = 4;
    step(1'b1, 1'b1, rbit(), rbit(), 1'b0, mk(1, 0, 0, 0, 0));
    idle_steps(2);
    run(1, 3, 2, -1, -1, -1); idle_steps(2);

    scen = 5; run(6, 4, 0, -1, 2, -1);  idle_steps(2);
    scen = 6; run(2, 0, 0, -1, -1, -1); idle_steps(1);
    scen = 7; run(0, 0, 0, -1, -1, -1); idle_steps(1);
    scen = 8; run(1, 6, 0, -1, -1, 4);  idle_steps(2);
    scen = 9; run(0, 5, 0, -1, 2, -1);  idle_steps(2);

    for (int r = 0; r < 12; r++) begin
      scen = 10 + r;
      s    = $urandom_range(0, 5);
      c    = $urandom_range(0, 8);
      fa   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1;
      aa   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
      run(s, c, 2, fa, aa, -1);
      idle_steps($urandom_range(0, 2));
    end

    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
